// File: rtl/dp_ram_pkg.sv
// Shared types and constants for the dual-port RAM controller.
package dp_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int unsigned WRITE_FIRST = 0;
    localparam int unsigned READ_FIRST  = 1;

endpackage

// File: rtl/dp_ram_outstage.sv
// Per-port read data / valid register pipeline.
// One stage by default; a second stage is added when DP_RAM_OUT_REG_EN is defined.
module dp_ram_outstage #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] q_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] s1_data_q;
    logic              s1_vld_q;

    // First stage: data holds when no request was accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_data_q <= '0;
            s1_vld_q  <= 1'b0;
        end else begin
            s1_vld_q <= load_i;
            if (load_i) begin
                s1_data_q <= data_i;
            end
        end
    end

`ifdef DP_RAM_OUT_REG_EN
    logic [DATA_W-1:0] s2_data_q;
    logic              s2_vld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_data_q <= '0;
            s2_vld_q  <= 1'b0;
        end else begin
            s2_data_q <= s1_data_q;
            s2_vld_q  <= s1_vld_q;
        end
    end

    assign q_o     = s2_data_q;
    assign valid_o = s2_vld_q;
`else
    assign q_o     = s1_data_q;
    assign valid_o = s1_vld_q;
`endif

endmodule

// File: rtl/dp_ram_ctrl.sv
// True dual-port RAM with post-reset clear sweep, read-during-write mode select
// and same-address write arbitration (port A wins). Optional macro: DP_RAM_OUT_REG_EN.
module dp_ram_ctrl
    import dp_ram_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned WRITE_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] q_a,
    output logic              valid_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] q_b,
    output logic              valid_b,
    output logic              busy,
    output logic              collision
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              busy_q;
    logic              collision_q;

    logic              acc_a_c, acc_b_c;
    logic              wr_a_c, wr_b_c;
    logic              same_wr_c;
    logic [DATA_W-1:0] rdata_a_c, rdata_b_c;

    // Requests are only accepted in IDLE and never on a reset edge
    assign acc_a_c   = en_a & ~busy_q & ~reset;
    assign acc_b_c   = en_b & ~busy_q & ~reset;
    assign wr_a_c    = acc_a_c & we_a;
    assign wr_b_c    = acc_b_c & we_b;
    assign same_wr_c = wr_a_c & wr_b_c & (addr_a == addr_b);

    // The other port's write lands at the edge, so cross-port reads see old data
    always_comb begin
        rdata_a_c = mem_q[addr_a];
        rdata_b_c = mem_q[addr_b];
        if (WRITE_MODE == WRITE_FIRST) begin
            if (wr_a_c) begin
                rdata_a_c = data_a;
            end
            if (wr_b_c) begin
                rdata_b_c = same_wr_c ? data_a : data_b;
            end
        end
    end

    // Port A is written last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR && !reset) begin
            mem_q[ptr_q] <= '0;
        end else begin
            if (wr_b_c) begin
                mem_q[addr_b] <= data_b;
            end
            if (wr_a_c) begin
                mem_q[addr_a] <= data_a;
            end
        end
    end

    // Clear sweep FSM and collision flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            busy_q      <= 1'b1;
            collision_q <= 1'b0;
        end else begin
            collision_q <= same_wr_c;
            case (state_q)
                ST_CLEAR: begin
                    ptr_q <= ptr_q + ADDR_W'(1);
                    if (ptr_q == LAST_PTR) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ptr_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign collision = collision_q;

    dp_ram_outstage #(.DATA_W(DATA_W)) u_out_a (
        .clk     (clk),
        .reset   (reset),
        .load_i  (acc_a_c),
        .data_i  (rdata_a_c),
        .q_o     (q_a),
        .valid_o (valid_a)
    );

    dp_ram_outstage #(.DATA_W(DATA_W)) u_out_b (
        .clk     (clk),
        .reset   (reset),
        .load_i  (acc_b_c),
        .data_i  (rdata_b_c),
        .q_o     (q_b),
        .valid_o (valid_b)
    );

endmodule

// File: tb/tb_dp_ram_ctrl.sv
// Directed bench for dp_ram_ctrl: one WRITE_FIRST and one READ_FIRST instance share stimulus.
module tb_dp_ram_ctrl;

`ifdef DP_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
    logic [9:0]  addr_a = '0, addr_b = '0;
    logic [15:0] data_a = '0, data_b = '0;

    logic [15:0] q_a, q_b, q_a_rf, q_b_rf;
    logic        valid_a, valid_b, busy, collision;
    logic        valid_a_rf, valid_b_rf, busy_rf, collision_rf;

    int checks = 0;
    int errors = 0;
    int cnt;

    always #5 clk = ~clk;

    dp_ram_ctrl #(.DATA_W(16), .ADDR_W(10), .WRITE_MODE(0)) dut (
        .clk(clk), .reset(reset),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a), .valid_a(valid_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b), .valid_b(valid_b),
        .busy(busy), .collision(collision)
    );

    dp_ram_ctrl #(.DATA_W(16), .ADDR_W(10), .WRITE_MODE(1)) dut_rf (
        .clk(clk), .reset(reset),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a_rf), .valid_a(valid_a_rf),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b_rf), .valid_b(valid_b_rf),
        .busy(busy_rf), .collision(collision_rf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of requests on both ports, then ports go quiet
    task automatic issue(input logic ea, input logic wa, input logic [9:0] aa, input logic [15:0] da,
                         input logic eb, input logic wb, input logic [9:0] ab, input logic [15:0] db);
        en_a = ea; we_a = wa; addr_a = aa; data_a = da;
        en_b = eb; we_b = wb; addr_b = ab; data_b = db;
        tick();
        en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
    endtask

    task automatic wait_out();
        for (int i = 1; i < LAT; i++) tick();
    endtask

    // Counts cycles from the reset edge until busy drops (bounded)
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 5000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        // 1: reset, full clear sweep, initial reads
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'd1);
        check_eq("rst_q_a", 32'(q_a), 32'h0);
        check_eq("rst_valid_a", 32'(valid_a), 32'd0);
        check_eq("rst_collision", 32'(collision), 32'd0);
        count_busy(cnt);
        check_eq("busy_cycles", 32'(cnt), 32'(DEPTH));

        issue(1, 0, 10'h001, 16'h0, 1, 0, 10'h3FF, 16'h0);
        wait_out();
        check_eq("init_q_a", 32'(q_a), 32'h0);
        check_eq("init_valid_a", 32'(valid_a), 32'd1);
        check_eq("init_q_b", 32'(q_b), 32'h0);
        check_eq("init_valid_b", 32'(valid_b), 32'd1);
        tick();
        check_eq("init_valid_a_pulse", 32'(valid_a), 32'd0);
        check_eq("init_valid_b_pulse", 32'(valid_b), 32'd0);

        // 2: write on A, read on B, hold
        issue(1, 1, 10'h001, 16'h0001, 0, 0, 10'h0, 16'h0);
        wait_out();
        check_eq("wr_valid_a", 32'(valid_a), 32'd1);
        issue(0, 0, 10'h0, 16'h0, 1, 0, 10'h001, 16'h0);
        wait_out();
        check_eq("rd_q_b", 32'(q_b), 32'h0001);
        check_eq("rd_valid_b", 32'(valid_b), 32'd1);
        tick();
        check_eq("rd_valid_b_pulse", 32'(valid_b), 32'd0);
        check_eq("hold_q_b", 32'(q_b), 32'h0001);
        tick();
        check_eq("hold_q_b2", 32'(q_b), 32'h0001);

        // 3: same-port read-during-write
        issue(1, 1, 10'h002, 16'h0002, 0, 0, 10'h0, 16'h0);
        wait_out();
        issue(1, 1, 10'h002, 16'h0003, 0, 0, 10'h0, 16'h0);
        wait_out();
        check_eq("rdw_wf_q_a", 32'(q_a), 32'h0003);
        check_eq("rdw_rf_q_a", 32'(q_a_rf), 32'h0002);
        issue(1, 0, 10'h002, 16'h0, 0, 0, 10'h0, 16'h0);
        wait_out();
        check_eq("rdw_after_wf", 32'(q_a), 32'h0003);
        check_eq("rdw_after_rf", 32'(q_a_rf), 32'h0003);

        // 4: cross-port read of an address being written
        issue(1, 1, 10'h003, 16'h00AA, 1, 0, 10'h003, 16'h0);
        wait_out();
        check_eq("xport_wf_q_b", 32'(q_b), 32'h0000);
        check_eq("xport_rf_q_b", 32'(q_b_rf), 32'h0000);
        issue(0, 0, 10'h0, 16'h0, 1, 0, 10'h003, 16'h0);
        wait_out();
        check_eq("xport_next_q_b", 32'(q_b), 32'h00AA);

        // 5: same-address dual write, then different-address dual write
        issue(1, 1, 10'h001, 16'h0004, 1, 1, 10'h001, 16'h0005);
        check_eq("coll_set", 32'(collision), 32'd1);
        check_eq("coll_set_rf", 32'(collision_rf), 32'd1);
        tick();
        check_eq("coll_pulse", 32'(collision), 32'd0);
        check_eq("coll_wf_q_a", 32'(q_a), 32'h0004);
        check_eq("coll_wf_q_b", 32'(q_b), 32'h0004);
        check_eq("coll_rf_q_b", 32'(q_b_rf), 32'h0001);
        issue(1, 0, 10'h001, 16'h0, 1, 0, 10'h001, 16'h0);
        wait_out();
        check_eq("coll_rd_a", 32'(q_a), 32'h0004);
        check_eq("coll_rd_b", 32'(q_b), 32'h0004);
        issue(1, 1, 10'h005, 16'h0011, 1, 1, 10'h006, 16'h0022);
        check_eq("nocoll", 32'(collision), 32'd0);
        wait_out();
        issue(1, 0, 10'h006, 16'h0, 1, 0, 10'h005, 16'h0);
        wait_out();
        check_eq("dual_rd_a", 32'(q_a), 32'h0022);
        check_eq("dual_rd_b", 32'(q_b), 32'h0011);

        // 6: reset mid-sweep restarts it; requests while busy are dropped
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (500) tick();
        check_eq("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        issue(1, 1, 10'h000, 16'h0077, 1, 0, 10'h000, 16'h0);
        check_eq("busy_valid_a", 32'(valid_a), 32'd0);
        check_eq("busy_valid_b", 32'(valid_b), 32'd0);
        tick();
        check_eq("busy_valid_a2", 32'(valid_a), 32'd0);
        count_busy(cnt);
        check_eq("rst2_busy_cycles", 32'(cnt + 3), 32'(DEPTH));
        issue(1, 0, 10'h000, 16'h0, 1, 0, 10'h005, 16'h0);
        if (LAT == 2) begin
            check_eq("lat2_not_yet", 32'(valid_a), 32'd0);
        end
        wait_out();
        check_eq("dropped_wr", 32'(q_a), 32'h0000);
        check_eq("cleared_rd", 32'(q_b), 32'h0000);
        check_eq("post_valid_a", 32'(valid_a), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
